hls_run_controller: RTL
=======================

# hls_run_controller

Synthesizable run controller for HLS-generated accelerator tops that expose a `start_port`/`done_port` handshake. It replaces single-shot bench sequencing with a parametrised engine that resets the DUT, pulses start, counts latency, applies a watchdog timeout and repeats for a programmable number of runs. Each run's status and cycle count go into a result FIFO. It sits between the accelerator top (`main`) and an on-chip host or monitor.

## Interface
- `CNT_W`, 32: width of the cycle counter and `res_cycles`.
- `TIMEOUT`, 200000000: maximum cycles per run before it is declared hung; must satisfy 1 ≤ TIMEOUT < 2^CNT_W.
- `RUNS_W`, 8: width of `cfg_runs` and `res_run_idx`.
- `RST_CYCLES`, 2: cycles `dut_reset` is held low before each start; must be ≥1.
- `RES_DEPTH`, 4: result FIFO depth; power of two, ≥2.

Ports:
- `clock` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-low.
- `go` in 1: one-cycle request to start a batch; sampled only in IDLE.
- `abort` in 1: synchronous; forces IDLE on the next edge from any state.
- `cfg_runs` in RUNS_W: number of runs in the batch; sampled when `go` is accepted.
- `dut_reset` out 1: active-low reset driven to the DUT.
- `dut_start` out 1: drives DUT `start_port`.
- `dut_done` in 1: DUT `done_port`.
- `res_valid` out 1: result FIFO is not empty.
- `res_ready` in 1: consumer pops the FIFO when both `res_valid` and `res_ready` are high.
- `res_status` out 2: status at the FIFO head; 2'b00 = done, 2'b01 = timeout.
- `res_cycles` out CNT_W: cycle count at the FIFO head.
- `res_run_idx` out RUNS_W: zero-based run index at the FIFO head.
- `busy` out 1: high in every state except IDLE.
- `all_done` out 1: one-cycle pulse when a batch completes.

## Operation
- States:
  - IDLE: `dut_reset`=0, `dut_start`=0.
  - DUT_RST: `dut_reset`=0.
  - START: `dut_reset`=1, `dut_start`=1.
  - RUN: `dut_reset`=1.
  - PUSH: `dut_reset`=1.
  - FINISH.
- IDLE, `go`=1 and `cfg_runs`≠0: latch `cfg_runs`, clear the run index, go to DUT_RST.
- IDLE, `go`=1 and `cfg_runs`=0: go to FINISH; no results are produced.
- DUT_RST: hold for exactly RST_CYCLES cycles, then go to START.
- START: lasts exactly one cycle; the cycle counter loads 1; go to RUN.
  - If `dut_done`=1 in the START cycle, record done with count 1 and go to PUSH.
- RUN:
  - Counter increments by 1 each cycle.
  - `dut_done`=1: record done with cycles = counter+1, inclusive of the start and done cycles.
  - Else if counter+1 == TIMEOUT: record timeout with cycles = TIMEOUT.
  - Either way, go to PUSH.
  - The counter never wraps, because TIMEOUT < 2^CNT_W.
- PUSH:
  - Write {status, cycles, run index} when the FIFO is not full.
  - If the FIFO is full, stay in PUSH with the DUT idle; the entry is held and never dropped.
  - After the write, if the index equals latched runs−1, go to FINISH; else increment the index and go to DUT_RST.
- FINISH: `all_done`=1 for one cycle; go to IDLE.
- `go` outside IDLE is ignored.
- `abort` beats every other transition. The FIFO contents are kept; a run in progress produces no entry; `all_done` is not pulsed.
- FIFO: a push and a pop in the same cycle on a full FIFO are both permitted. Pointers wrap modulo RES_DEPTH.

## Timing
- Reset values:
  - `dut_reset`=0, `dut_start`=0, `busy`=0, `all_done`=0, `res_valid`=0.
  - `res_status`, `res_cycles` and `res_run_idx` are 0.
  - State is IDLE; all counters are 0; the FIFO is empty.
- All outputs are registered or decoded from registered state. There is no combinational path from `dut_done` to any output.
- Timing from `go` accepted at edge N:
  - DUT_RST occupies cycles N+1 .. N+RST_CYCLES.
  - `dut_start` is high in cycle N+RST_CYCLES+1.
- Done sampled L cycles after the start cycle: `res_cycles`=L+1, and `res_valid` rises 2 cycles after done is sampled (assuming FIFO not full).
- Run-to-run overhead when the FIFO is not full: 1 PUSH cycle plus RST_CYCLES.
- Asynchronous `reset` mid-batch: immediate return to reset values, the FIFO is flushed, and `dut_reset` is asserted.

## Structure
- Package `hls_run_ctrl_pkg` holds:
  - the state enum;
  - status codes `ST_DONE` = 2'b00 and `ST_TIMEOUT` = 2'b01;
  - the result record type {status, cycles, run_idx}.
- One sub-module, `hls_result_fifo`: synchronous, parametrised by width and RES_DEPTH, with a full/empty flag and show-ahead read.
- The controller FSM, counter and run index stay in the top.

## Test plan
- RST_CYCLES=2, `cfg_runs`=1, DUT model raises done 9 cycles after start:
  - `dut_reset` is low for 2 cycles, `dut_start` pulses once;
  - one result {00, 10, 0}; `all_done` pulses once.
- TIMEOUT=50, DUT never done:
  - result {01, 50, 0};
  - `dut_reset` is reasserted afterwards.
- `cfg_runs`=6, RES_DEPTH=4, `res_ready`=0 until cycle 200:
  - controller stalls in PUSH on the 5th result;
  - after draining, six results with indices 0..5 in order, none lost.
- `abort` during RUN of run 2 of 4:
  - IDLE next cycle, no entry for run 2, no `all_done`;
  - earlier results remain readable.
- `go` with `cfg_runs`=0: `all_done` pulses 2 cycles later, `res_valid` stays 0.
- `go` re-asserted while busy and `dut_done` high in the START cycle:
  - the extra `go` is ignored;
  - the START-cycle done gives `res_cycles`=1.

Source files
------------

// File: rtl/hls_run_ctrl_pkg.sv
// Shared types for the HLS run controller.
//   state_e   : controller FSM states
//   ST_*      : result status codes
//   res_rec_t : one result FIFO entry {status, cycles, run_idx}.
//               The field widths are the largest CNT_W / RUNS_W the
//               controller supports.
package hls_run_ctrl_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_DUT_RST,
    S_START,
    S_RUN,
    S_PUSH,
    S_FINISH
  } state_e;

  localparam logic [1:0] ST_DONE    = 2'b00;
  localparam logic [1:0] ST_TIMEOUT = 2'b01;

  localparam int unsigned REC_CNT_W  = 32;
  localparam int unsigned REC_RUNS_W = 8;

  typedef struct packed {
    logic [1:0]            status;
    logic [REC_CNT_W-1:0]  cycles;
    logic [REC_RUNS_W-1:0] run_idx;
  } res_rec_t;

endpackage

// File: rtl/hls_result_fifo.sv
// Synchronous result FIFO with show-ahead read.
//   gclk_i / grst_ni : clock, async active-low reset (pointers only)
//   wr_en_i, wr_data_i : push request and data
//   rd_en_i            : pop request; ignored when empty
//   rd_data_o          : head entry, zero while empty
//   full_o, empty_o    : occupancy flags
// A push into a full FIFO is accepted when a pop happens in the same cycle.
module hls_result_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic         gclk_i,
  input  logic         grst_ni,
  input  logic         wr_en_i,
  input  logic [W-1:0] wr_data_i,
  input  logic         rd_en_i,
  output logic [W-1:0] rd_data_o,
  output logic         full_o,
  output logic         empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem_q [DEPTH];
  logic [AW:0]  wp_q, rp_q;
  logic         push, pop;

  // Extra pointer bit distinguishes full from empty when the indices match.
  assign empty_o = (wp_q == rp_q);
  assign full_o  = (wp_q[AW] != rp_q[AW]) && (wp_q[AW-1:0] == rp_q[AW-1:0]);
  assign pop     = rd_en_i && !empty_o;
  assign push    = wr_en_i && (!full_o || pop);

  always_ff @(posedge gclk_i or negedge grst_ni) begin
    if (!grst_ni) begin
      wp_q <= '0;
      rp_q <= '0;
    end else begin
      if (push) wp_q <= wp_q + (AW+1)'(1);
      if (pop)  rp_q <= rp_q + (AW+1)'(1);
    end
  end

  always_ff @(posedge gclk_i) begin
    if (push) mem_q[wp_q[AW-1:0]] <= wr_data_i;
  end

  // Gating the head keeps the outputs at zero out of reset without
  // resetting the storage array.
  assign rd_data_o = empty_o ? '0 : mem_q[rp_q[AW-1:0]];

endmodule

// File: rtl/hls_run_controller.sv
// Run controller for an HLS accelerator with a start_port/done_port handshake.
// Resets the accelerator, pulses start, counts latency with a watchdog and
// repeats for cfg_runs runs. Each run's result is pushed to a FIFO.
//   clock, reset      : clock, async active-low reset
//   go, cfg_runs      : batch request (taken in IDLE) and its run count
//   abort             : synchronous return to IDLE from any state
//   dut_reset/_start  : accelerator reset (active low) and start
//   dut_done          : accelerator done
//   res_*             : result FIFO head with valid/ready pop
//   busy, all_done    : not-IDLE flag, batch-complete pulse
module hls_run_controller
  import hls_run_ctrl_pkg::*;
#(
  parameter int unsigned CNT_W      = 32,
  parameter int unsigned TIMEOUT    = 200000000,
  parameter int unsigned RUNS_W     = 8,
  parameter int unsigned RST_CYCLES = 2,
  parameter int unsigned RES_DEPTH  = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              go,
  input  logic              abort,
  input  logic [RUNS_W-1:0] cfg_runs,
  output logic              dut_reset,
  output logic              dut_start,
  input  logic              dut_done,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [1:0]        res_status,
  output logic [CNT_W-1:0]  res_cycles,
  output logic [RUNS_W-1:0] res_run_idx,
  output logic              busy,
  output logic              all_done
);

  localparam int RC_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam logic [RC_W-1:0]  RC_LAST = RC_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] TMO     = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

  state_e            state_q, state_d;
  logic [RC_W-1:0]   rcnt_q, rcnt_d;
  logic [CNT_W-1:0]  cyc_q, cyc_d, cyc_inc;
  logic [RUNS_W-1:0] idx_q, idx_d, runs_q, runs_d;
  logic [1:0]        rstat_q, rstat_d;
  logic [CNT_W-1:0]  rcyc_q, rcyc_d;

  logic     fifo_full, fifo_empty, can_push, push_en;
  res_rec_t wr_rec, head;

  assign cyc_inc  = cyc_q + ONE;
  // A pop in the same cycle frees the slot, so a full FIFO can still accept.
  assign can_push = !fifo_full || res_ready;
  assign push_en  = (state_q == S_PUSH) && !abort && can_push;

  // State and datapath registers
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      rcnt_q  <= '0;
      cyc_q   <= '0;
      idx_q   <= '0;
      runs_q  <= '0;
      rstat_q <= ST_DONE;
      rcyc_q  <= '0;
    end else begin
      state_q <= state_d;
      rcnt_q  <= rcnt_d;
      cyc_q   <= cyc_d;
      idx_q   <= idx_d;
      runs_q  <= runs_d;
      rstat_q <= rstat_d;
      rcyc_q  <= rcyc_d;
    end
  end

  // Next state
  always_comb begin
    state_d = state_q;
    rcnt_d  = rcnt_q;
    cyc_d   = cyc_q;
    idx_d   = idx_q;
    runs_d  = runs_q;
    rstat_d = rstat_q;
    rcyc_d  = rcyc_q;
    unique case (state_q)
      S_IDLE: begin
        if (go) begin
          if (cfg_runs != '0) begin
            runs_d  = cfg_runs;
            idx_d   = '0;
            rcnt_d  = '0;
            state_d = S_DUT_RST;
          end else begin
            state_d = S_FINISH;
          end
        end
      end
      S_DUT_RST: begin
        if (rcnt_q == RC_LAST) state_d = S_START;
        else                   rcnt_d  = rcnt_q + RC_W'(1);
      end
      S_START: begin
        // The start cycle is cycle 1 of the run.
        cyc_d = ONE;
        if (dut_done) begin
          rstat_d = ST_DONE;
          rcyc_d  = ONE;
          state_d = S_PUSH;
        end else if (TMO == ONE) begin
          rstat_d = ST_TIMEOUT;
          rcyc_d  = TMO;
          state_d = S_PUSH;
        end else begin
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        cyc_d = cyc_inc;
        if (dut_done) begin
          rstat_d = ST_DONE;
          rcyc_d  = cyc_inc;
          state_d = S_PUSH;
        end else if (cyc_inc == TMO) begin
          rstat_d = ST_TIMEOUT;
          rcyc_d  = TMO;
          state_d = S_PUSH;
        end
      end
      S_PUSH: begin
        if (can_push) begin
          if (idx_q == runs_q - RUNS_W'(1)) begin
            state_d = S_FINISH;
          end else begin
            idx_d   = idx_q + RUNS_W'(1);
            rcnt_d  = '0;
            state_d = S_DUT_RST;
          end
        end
      end
      S_FINISH: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
    if (abort) state_d = S_IDLE;
  end

  // Outputs decoded from state only
  always_comb begin
    dut_reset = 1'b0;
    dut_start = 1'b0;
    busy      = 1'b1;
    all_done  = 1'b0;
    unique case (state_q)
      S_IDLE:        busy = 1'b0;
      S_DUT_RST:     dut_reset = 1'b0;
      S_START: begin
        dut_reset = 1'b1;
        dut_start = 1'b1;
      end
      S_RUN, S_PUSH: dut_reset = 1'b1;
      S_FINISH:      all_done = 1'b1;
      default:       busy = 1'b0;
    endcase
  end

  assign wr_rec = '{status:  rstat_q,
                    cycles:  REC_CNT_W'(rcyc_q),
                    run_idx: REC_RUNS_W'(idx_q)};

  hls_result_fifo #(
    .W     ($bits(res_rec_t)),
    .DEPTH (RES_DEPTH)
  ) u_fifo (
    .gclk_i    (clock),
    .grst_ni   (reset),
    .wr_en_i   (push_en),
    .wr_data_i (wr_rec),
    .rd_en_i   (res_ready),
    .rd_data_o (head),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty)
  );

  assign res_valid   = !fifo_empty;
  assign res_status  = head.status;
  assign res_cycles  = head.cycles[CNT_W-1:0];
  assign res_run_idx = head.run_idx[RUNS_W-1:0];

endmodule
